// File: rtl/fx_pkg.sv
// Shared fixed-point definitions for the Q16.16 datapath blocks.
// Holds the default format, saturation limits and the ln(1+t) constant generator.
package fx_pkg;

   localparam int FX_WIDTH    = 32;
   localparam int FX_QINT     = 16;
   localparam int FX_QFRAC    = FX_WIDTH - FX_QINT;
   localparam int FX_LUT_BITS = 10;

   typedef logic signed [FX_WIDTH-1:0] fx_t;

   localparam fx_t FX_MAX = {1'b0, {(FX_WIDTH-1){1'b1}}};
   localparam fx_t FX_MIN = {1'b1, {(FX_WIDTH-1){1'b0}}};

   // round(ln(1 + num/den) * 2^qfrac) via ln(1+t) = 2*atanh(t/(2+t)), evaluated in Q30
   function automatic longint ln1p_q(input longint num, input longint den, input int qfrac);
      longint y;
      longint y2;
      longint term;
      longint acc;
      y    = (num <<< 30) / (2 * den + num);
      y2   = (y * y) >>> 30;
      term = y;
      acc  = 0;
      for (int n = 0; n < 20; n++) begin
         acc  = acc + term / longint'(2 * n + 1);
         term = (term * y2) >>> 30;
      end
      acc = acc * 2;
      return (acc + (longint'(1) <<< (29 - qfrac))) >>> (30 - qfrac);
   endfunction

   localparam longint LN2_Q = ln1p_q(1, 1, FX_QFRAC);

endpackage

// File: rtl/fx_lzc.sv
// Combinational leading-one detector: position of the most significant set bit
// and a flag for an all-zero word. Shared by the normalising datapath blocks.
module fx_lzc #(
   parameter int WIDTH = 32,
   parameter int PW    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] word,
   output logic [PW-1:0]    pos,
   output logic             zero
);

   // Scanning upward lets the highest set bit win.
   always_comb begin
      pos  = '0;
      zero = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         if (word[i]) begin
            pos  = PW'(i);
            zero = 1'b0;
         end
      end
   end

endmodule

// File: rtl/fx_log_lut.sv
// Three-stage pipelined fixed-point natural log: ln(x) = e*ln2 + ln(1+f),
// with ln(1+f) taken from a table indexed by the mantissa bits below the leading one.
module fx_log_lut
   import fx_pkg::*;
#(
   parameter int WIDTH    = FX_WIDTH,
   parameter int QINT     = FX_QINT,
   parameter int QFRAC    = WIDTH - QINT,
   parameter int LUT_BITS = FX_LUT_BITS
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   output logic                    ready_out,
   input  logic signed [WIDTH-1:0] x,
   output logic                    valid_out,
   input  logic                    ready_in,
   output logic signed [WIDTH-1:0] ln_result,
   output logic                    err_out
);

   localparam int PW    = $clog2(WIDTH);
   localparam int E_W   = PW + 1;
   localparam int DEPTH = 1 << LUT_BITS;
   localparam int XW    = WIDTH + 6;
   localparam int SUM_W = WIDTH + 7;

   localparam logic signed [XW-1:0]    LN2 = (QFRAC == FX_QFRAC) ? XW'(LN2_Q)
                                                                 : XW'(ln1p_q(1, 1, QFRAC));
   localparam logic signed [SUM_W-1:0] SAT_HI = (SUM_W'(1) <<< (WIDTH - 1)) - SUM_W'(1);
   localparam logic signed [SUM_W-1:0] SAT_LO = -(SUM_W'(1) <<< (WIDTH - 1));

   // Table entry k = round(ln(1 + k/DEPTH) * 2^QFRAC), fixed at elaboration.
   logic [WIDTH-1:0] rom [DEPTH];
   for (genvar k = 0; k < DEPTH; k++) begin : g_rom
      localparam longint ENTRY = ln1p_q(longint'(k), longint'(DEPTH), QFRAC);
      assign rom[k] = WIDTH'(ENTRY);
   end

   logic                    en;
   logic [PW-1:0]           lead_pos;
   logic                    x_zero;
   logic [PW-1:0]           shift;
   logic [WIDTH-1:0]        aligned;
   logic [LUT_BITS-1:0]     idx_next;
   logic signed [E_W-1:0]   e_next;
   logic                    err_next;

   logic                    v1;
   logic signed [E_W-1:0]   e1;
   logic [LUT_BITS-1:0]     idx1;
   logic                    err1;

   logic                    v2;
   logic [WIDTH-1:0]        lut_q;
   logic signed [XW-1:0]    exp_term;
   logic                    err2;

   logic signed [SUM_W-1:0] sum;
   logic signed [WIDTH-1:0] res_next;

   assign en        = !valid_out || ready_in;
   assign ready_out = en;

   fx_lzc #(.WIDTH(WIDTH), .PW(PW)) u_lzc (
      .word (x),
      .pos  (lead_pos),
      .zero (x_zero)
   );

   // Left-align so the leading one sits at the MSB; the index is the bits just below it.
   assign shift    = PW'(WIDTH - 1) - lead_pos;
   assign aligned  = x << shift;
   assign idx_next = LUT_BITS'(aligned >> (WIDTH - 1 - LUT_BITS));
   assign e_next   = $signed({1'b0, lead_pos}) - E_W'(QFRAC);
   assign err_next = x[WIDTH-1] | x_zero;

   always_comb begin
      sum = SUM_W'(exp_term) + SUM_W'($signed({1'b0, lut_q}));
      if (err2) begin
         res_next = WIDTH'(SAT_LO);
      end else if (sum > SAT_HI) begin
         res_next = WIDTH'(SAT_HI);
      end else if (sum < SAT_LO) begin
         res_next = WIDTH'(SAT_LO);
      end else begin
         res_next = WIDTH'(sum);
      end
   end

   // Whole pipe, bubbles included, moves together on en so a stall freezes every stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1        <= 1'b0;
         e1        <= '0;
         idx1      <= '0;
         err1      <= 1'b0;
         v2        <= 1'b0;
         lut_q     <= '0;
         exp_term  <= '0;
         err2      <= 1'b0;
         valid_out <= 1'b0;
         ln_result <= '0;
         err_out   <= 1'b0;
      end else if (en) begin
         v1        <= valid_in;
         e1        <= e_next;
         idx1      <= idx_next;
         err1      <= err_next;
         v2        <= v1;
         lut_q     <= rom[idx1];
         exp_term  <= XW'(e1) * LN2;
         err2      <= err1;
         valid_out <= v2;
         ln_result <= res_next;
         err_out   <= err2;
      end
   end

endmodule

// File: tb/tb_fx_log_lut.sv
// Scoreboard bench for fx_log_lut: directed log values, domain errors, a back-pressured
// burst, mid-stream reset and a random sweep checked against a real-valued model.
module tb_fx_log_lut;
   import fx_pkg::*;

   typedef struct {
      fx_t  res;
      logic err;
      int   tol;
      int   acc;
      bit   chkLat;
   } exp_t;

   logic clk;
   logic rst_n;
   logic valid_in;
   logic ready_out;
   fx_t  x;
   logic valid_out;
   logic ready_in;
   fx_t  ln_result;
   logic err_out;

   int   nChecks = 0;
   int   nFails  = 0;
   int   cyc     = 0;
   exp_t sb[$];
   exp_t got;
   bit   heldValid = 0;
   fx_t  heldRes;
   logic heldErr;
   bit   randReady = 0;

   fx_log_lut dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .x         (x),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .ln_result (ln_result),
      .err_out   (err_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input longint obs, input longint exp);
      nChecks++;
      if (obs != exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Exponent term uses the quantised ln2 constant; the mantissa term is exact real ln.
   function automatic longint modelLn(input fx_t v);
      int  p;
      real m;
      real r;
      p = 0;
      for (int i = 0; i < FX_WIDTH - 1; i++) begin
         if (v[i]) p = i;
      end
      m = real'(v) / (2.0 ** p);
      r = real'(p - FX_QFRAC) * 45426.0 + $ln(m) * 65536.0;
      return longint'(r);
   endfunction

   task automatic applyStimulus(input fx_t xv, input fx_t res, input logic err,
                                input int tol, input bit chkLat);
      exp_t e;
      bit   done;
      done     = 0;
      valid_in = 1'b1;
      x        = xv;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (ready_out) begin
            e.res    = res;
            e.err    = err;
            e.tol    = tol;
            e.acc    = cyc;
            e.chkLat = chkLat;
            sb.push_back(e);
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) checkOutput("accept_timeout", 0, 1);
   endtask

   task automatic applyModel(input fx_t xv);
      applyStimulus(xv, fx_t'(modelLn(xv)), 1'b0, 65, 1'b0);
   endtask

   task automatic waitDrain();
      bit empty;
      empty = 0;
      for (int n = 0; n < 300 && !empty; n++) begin
         @(negedge clk);
         if (sb.size() == 0) empty = 1;
      end
      if (!empty) checkOutput("drain_timeout", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Output monitor: stall stability, ready_out under back-pressure, scoreboard pops.
   always @(negedge clk) begin
      if (rst_n && heldValid) begin
         checkOutput("hold_valid", valid_out, 1);
         checkOutput("hold_result", ln_result, heldRes);
         checkOutput("hold_err", err_out, heldErr);
      end
      if (rst_n && valid_out && !ready_in) checkOutput("ready_out_stall", ready_out, 0);
      heldValid = rst_n && valid_out && !ready_in;
      heldRes   = ln_result;
      heldErr   = err_out;
      if (rst_n && valid_out && ready_in) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_out", 1, 0);
         end else begin
            got = sb.pop_front();
            if (got.tol == 0) begin
               checkOutput("ln_result", ln_result, got.res);
            end else begin
               longint diff;
               diff = longint'(ln_result) - longint'(got.res);
               if (diff < 0) diff = -diff;
               checkOutput("ln_within_tol", diff <= longint'(got.tol), 1);
            end
            checkOutput("err_out", err_out, got.err);
            if (got.chkLat) checkOutput("latency", cyc - got.acc, 3);
         end
      end
   end

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n    = 1'b0;
      valid_in = 1'b0;
      x        = '0;
      ready_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_valid_out", valid_out, 0);
      checkOutput("rst_err_out", err_out, 0);
      checkOutput("rst_ln_result", ln_result, 0);
      checkOutput("rst_ready_out", ready_out, 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Isolated 1.0 for the latency measurement, then directed values back-to-back.
      applyStimulus(32'h0001_0000, 32'h0000_0000, 1'b0, 0, 1'b1);
      valid_in = 1'b0;
      waitDrain();
      applyStimulus(32'h0002_0000, 32'h0000_B172, 1'b0, 0, 1'b0);
      applyStimulus(32'h0000_8000, 32'hFFFF_4E8E, 1'b0, 0, 1'b0);
      applyStimulus(32'h0000_0001, 32'hFFF4_E8E0, 1'b0, 0, 1'b0);
      applyStimulus(32'h0002_B7E1, 32'h0001_0000, 1'b0, 65, 1'b0);
      applyModel(FX_MAX);
      applyStimulus(32'h0000_0000, FX_MIN, 1'b1, 0, 1'b0);
      applyStimulus(32'hFFFF_0000, FX_MIN, 1'b1, 0, 1'b0);
      applyStimulus(FX_MIN, FX_MIN, 1'b1, 0, 1'b0);
      applyStimulus(32'h0001_0000, 32'h0000_0000, 1'b0, 0, 1'b0);
      valid_in = 1'b0;
      waitDrain();

      // Burst of 8 with ready_in low for burst cycles 4..7.
      fork
         begin
            for (int i = 1; i <= 8; i++) applyModel(fx_t'(i * 32'h0000_5A3C));
            valid_in = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            #1 ready_in = 1'b0;
            repeat (4) @(posedge clk);
            #1 ready_in = 1'b1;
         end
      join
      waitDrain();

      // Reset with three samples in flight: they must vanish.
      applyStimulus(32'h0003_0000, 32'h0000_0000, 1'b0, 0, 1'b0);
      applyStimulus(32'h0004_0000, 32'h0000_0000, 1'b0, 0, 1'b0);
      applyStimulus(32'h0005_0000, 32'h0000_0000, 1'b0, 0, 1'b0);
      valid_in = 1'b0;
      rst_n    = 1'b0;
      #1;
      checkOutput("async_rst_valid", valid_out, 0);
      checkOutput("async_rst_result", ln_result, 0);
      checkOutput("async_rst_err", err_out, 0);
      sb.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(32'h0001_0000, 32'h0000_0000, 1'b0, 0, 1'b1);
      valid_in = 1'b0;
      waitDrain();

      // Random positive sweep with random back-pressure.
      randReady = 1;
      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               logic [31:0] r;
               r = $urandom() >> (1 + $urandom_range(0, 30));
               if (r == 0) r = 32'd1;
               applyModel(fx_t'(r));
            end
            valid_in  = 1'b0;
            randReady = 0;
         end
         begin
            while (randReady) begin
               @(posedge clk);
               #1 ready_in = ($urandom_range(0, 3) != 0);
            end
            ready_in = 1'b1;
         end
      join
      ready_in = 1'b1;
      waitDrain();

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
      $finish;
   end

endmodule
